karatsuba8_uc: RTL

Control unit for the 8×8 Karatsuba multiplier datapath (`karatusuba8_fd`). It captures the operands on a start request and sequences the shared 5×5 multiplier, the 16-bit adder/subtractor and the A–E registers through a fixed 6-step schedule. It then signals completion, leaving `R` valid. It sits beside the datapath inside the `karatsuba8` top and drives every datapath control input.

---
 rtl/karatsuba8_pkg.sv | 94 +++++++++
 rtl/karatsuba8_uc.sv | 76 +++++++
 2 files changed

// File: rtl/karatsuba8_pkg.sv
// Shared encodings for the karatsuba8 multiplier control path:
// FSM states, datapath select codes and the per-state control word.
package karatsuba8_pkg;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SUMX = 3'd1;
  localparam logic [2:0] S_SUMY = 3'd2;
  localparam logic [2:0] S_MID  = 3'd3;
  localparam logic [2:0] S_Z1   = 3'd4;
  localparam logic [2:0] S_HIGH = 3'd5;
  localparam logic [2:0] S_ACC  = 3'd6;
  localparam logic [2:0] S_DONE = 3'd7;

  localparam logic [1:0] MUL_LO = 2'b00;
  localparam logic [1:0] MUL_HI = 2'b01;
  localparam logic [1:0] MUL_CD = 2'b10;

  localparam logic [2:0] SS_XSUM = 3'b000;
  localparam logic [2:0] SS_YSUM = 3'b001;
  localparam logic [2:0] SS_AB   = 3'b010;
  localparam logic [2:0] SS_CE   = 3'b011;
  localparam logic [2:0] SS_AB8  = 3'b100;
  localparam logic [2:0] SS_AC4  = 3'b101;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       a_ld;
    logic       b_ld;
    logic       c_ld;
    logic       d_ld;
    logic       e_ld;
    logic       sub;
    logic       a_sel;
    logic       c_sel;
    logic [1:0] mul_sel;
    logic [2:0] ss_sel;
  } ctl_t;

  // Moore part of the control word, one entry per state.
  function automatic ctl_t ctl_decode(input logic [2:0] s);
    ctl_t c;
    c = '0;
    case (s)
      S_SUMX: begin
        c.busy    = 1'b1;
        c.mul_sel = MUL_LO;
        c.a_ld    = 1'b1;
        c.ss_sel  = SS_XSUM;
        c.c_sel   = 1'b1;
        c.c_ld    = 1'b1;
      end
      S_SUMY: begin
        c.busy    = 1'b1;
        c.mul_sel = MUL_HI;
        c.b_ld    = 1'b1;
        c.ss_sel  = SS_YSUM;
        c.d_ld    = 1'b1;
      end
      S_MID: begin
        c.busy    = 1'b1;
        c.mul_sel = MUL_CD;
        c.c_ld    = 1'b1;
        c.ss_sel  = SS_AB;
        c.e_ld    = 1'b1;
      end
      S_Z1: begin
        c.busy   = 1'b1;
        c.ss_sel = SS_CE;
        c.sub    = 1'b1;
        c.c_sel  = 1'b1;
        c.c_ld   = 1'b1;
      end
      S_HIGH: begin
        c.busy   = 1'b1;
        c.ss_sel = SS_AB8;
        c.a_sel  = 1'b1;
        c.a_ld   = 1'b1;
      end
      S_ACC: begin
        c.busy   = 1'b1;
        c.ss_sel = SS_AC4;
        c.a_sel  = 1'b1;
        c.a_ld   = 1'b1;
      end
      S_DONE: begin
        c.done = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/karatsuba8_uc.sv
// Control unit for the 8x8 Karatsuba datapath: a single state
// register walking a fixed six-step schedule, plus output decode.
module karatsuba8_uc
  import karatsuba8_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       x_ld,
  output logic       y_ld,
  output logic       a_ld,
  output logic       b_ld,
  output logic       c_ld,
  output logic       d_ld,
  output logic       e_ld,
  output logic       sub,
  output logic       a_sel,
  output logic       c_sel,
  output logic [1:0] mul_sel,
  output logic [2:0] ss_sel
);

  logic [2:0] r_state;
  logic [2:0] w_next;
  logic       w_go;
  ctl_t       w_ctl;

  // Operands are captured only when a request arrives in IDLE;
  // rst masks the Mealy load so nothing is captured during reset.
  assign w_go = (r_state == S_IDLE) & start & ~rst;

  // State register, asynchronously forced to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Fixed schedule; start is ignored everywhere except IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = start ? S_SUMX : S_IDLE;
      S_SUMX:  w_next = S_SUMY;
      S_SUMY:  w_next = S_MID;
      S_MID:   w_next = S_Z1;
      S_Z1:    w_next = S_HIGH;
      S_HIGH:  w_next = S_ACC;
      S_ACC:   w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Control word is a pure decode of the current state.
  always_comb begin
    w_ctl = ctl_decode(r_state);
  end

  assign busy    = w_ctl.busy;
  assign done    = w_ctl.done;
  assign a_ld    = w_ctl.a_ld;
  assign b_ld    = w_ctl.b_ld;
  assign c_ld    = w_ctl.c_ld;
  assign d_ld    = w_ctl.d_ld;
  assign e_ld    = w_ctl.e_ld;
  assign sub     = w_ctl.sub;
  assign a_sel   = w_ctl.a_sel;
  assign c_sel   = w_ctl.c_sel;
  assign mul_sel = w_ctl.mul_sel;
  assign ss_sel  = w_ctl.ss_sel;
  assign x_ld    = w_go;
  assign y_ld    = w_go;

endmodule
